// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I sequencer: FSM states, halt causes,
// the opcode map and the legal-opcode predicate used by DECODE.
package ctrl_pkg;

   typedef enum logic [2:0] {
      ST_FETCH  = 3'd0,
      ST_DECODE = 3'd1,
      ST_EXEC   = 3'd2,
      ST_MEM    = 3'd3,
      ST_WB     = 3'd4,
      ST_HALT   = 3'd5
   } state_t;

   typedef enum logic [1:0] {
      HC_NONE    = 2'b00,
      HC_SYSTEM  = 2'b01,
      HC_ILLEGAL = 2'b10,
      HC_TIMEOUT = 2'b11
   } halt_cause_t;

   localparam logic [6:0] OP_REG    = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;

   function automatic logic is_exec_op(input logic [6:0] op);
      case (op)
         OP_REG, OP_IMM, OP_LUI, OP_AUIPC, OP_LOAD,
         OP_STORE, OP_BRANCH, OP_JAL, OP_JALR: is_exec_op = 1'b1;
         default:                               is_exec_op = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/multicycle_seq_ctrl_mem_wait_watchdog.sv
// Memory-wait watchdog: counts consecutive unanswered request cycles and flags
// the cycle in which the MEM_WAIT_MAX-th wait occurs.
module mem_wait_watchdog #(
   parameter int unsigned MEM_WAIT_MAX = 255
) (
   input  logic clk,
   input  logic rst,
   input  logic i_clr,
   input  logic i_inc,
   output logic o_expire
);

   localparam int unsigned W = $clog2(MEM_WAIT_MAX + 1);

   logic [W-1:0] r_cnt;

   always_ff @(posedge clk) begin
      if (rst || i_clr) begin
         r_cnt <= '0;
      end else if (i_inc) begin
         r_cnt <= r_cnt + W'(1);
      end
   end

   // Expire on the wait cycle that would bring the count to MEM_WAIT_MAX.
   assign o_expire = i_inc && (r_cnt == W'(MEM_WAIT_MAX - 1));

endmodule

// File: rtl/multicycle_seq_ctrl.sv
// Multi-cycle RV32I sequencer: Moore state, Mealy register enables, req/ready memory port.
// Optional saturating memory-stall counter when STALL_COUNT_EN is defined.
//
// state   | meaning
// FETCH   | request instruction at PC; load IR and PC+4 on ready
// DECODE  | latch A/B operands, classify opcode
// EXEC    | ALU op into ALUOUT; branches/jumps update PC here
// MEM     | data access at ALUOUT (load -> MDR, store completes)
// WB      | single-cycle register-file write
// HALT    | absorbing until rst; cause held in halt_cause
module multicycle_seq_ctrl
   import ctrl_pkg::*;
#(
   parameter int unsigned MEM_WAIT_MAX = 255,
   parameter int unsigned CNT_W        = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [6:0]       opcode,
   input  logic             br_taken,
   input  logic             mem_ready,
   output logic             mem_req,
   output logic             mem_we,
   output logic             addr_sel,
   output logic             pc_en,
   output logic             pc_sel,
   output logic             ir_en,
   output logic             ab_en,
   output logic             aluout_en,
   output logic             mdr_en,
   output logic             rf_we,
   output logic             halted,
   output logic [1:0]       halt_cause,
   output logic [CNT_W-1:0] retired
`ifdef STALL_COUNT_EN
   ,
   output logic [CNT_W-1:0] stall_cycles
`endif
);

   state_t      r_state, w_next;
   halt_cause_t r_cause, w_cause_next;
   logic [CNT_W-1:0] r_retired;

   logic w_mem_req, w_mem_we, w_addr_sel, w_pc_en, w_pc_sel, w_ir_en;
   logic w_ab_en, w_aluout_en, w_mdr_en, w_rf_we, w_retire;
   logic w_wait, w_expire;

   assign w_wait = ((r_state == ST_FETCH) || (r_state == ST_MEM)) && !mem_ready;

   mem_wait_watchdog #(.MEM_WAIT_MAX(MEM_WAIT_MAX)) u_watchdog (
      .clk      (clk),
      .rst      (rst),
      .i_clr    (!w_wait),
      .i_inc    (w_wait),
      .o_expire (w_expire)
   );

   always_comb begin
      w_next       = r_state;
      w_cause_next = r_cause;
      w_mem_req    = 1'b0;
      w_mem_we     = 1'b0;
      w_addr_sel   = 1'b0;
      w_pc_en      = 1'b0;
      w_pc_sel     = 1'b0;
      w_ir_en      = 1'b0;
      w_ab_en      = 1'b0;
      w_aluout_en  = 1'b0;
      w_mdr_en     = 1'b0;
      w_rf_we      = 1'b0;
      w_retire     = 1'b0;
      case (r_state)
         ST_FETCH: begin
            w_mem_req = 1'b1;
            if (mem_ready) begin
               w_ir_en = 1'b1;
               w_pc_en = 1'b1;
               w_next  = ST_DECODE;
            end else if (w_expire) begin
               w_next       = ST_HALT;
               w_cause_next = HC_TIMEOUT;
            end
         end
         ST_DECODE: begin
            w_ab_en = 1'b1;
            if (opcode == OP_SYSTEM) begin
               w_next       = ST_HALT;
               w_cause_next = HC_SYSTEM;
            end else if (is_exec_op(opcode)) begin
               w_next = ST_EXEC;
            end else begin
               w_next       = ST_HALT;
               w_cause_next = HC_ILLEGAL;
            end
         end
         ST_EXEC: begin
            w_aluout_en = 1'b1;
            case (opcode)
               OP_BRANCH: begin
                  w_pc_en  = br_taken;
                  w_pc_sel = 1'b1;
                  w_retire = 1'b1;
                  w_next   = ST_FETCH;
               end
               OP_JAL, OP_JALR: begin
                  w_pc_en  = 1'b1;
                  w_pc_sel = 1'b1;
                  w_next   = ST_WB;
               end
               OP_LOAD, OP_STORE: w_next = ST_MEM;
               default:           w_next = ST_WB;
            endcase
         end
         ST_MEM: begin
            w_mem_req  = 1'b1;
            w_addr_sel = 1'b1;
            w_mem_we   = (opcode == OP_STORE);
            if (mem_ready) begin
               if (opcode == OP_STORE) begin
                  w_retire = 1'b1;
                  w_next   = ST_FETCH;
               end else begin
                  w_mdr_en = 1'b1;
                  w_next   = ST_WB;
               end
            end else if (w_expire) begin
               w_next       = ST_HALT;
               w_cause_next = HC_TIMEOUT;
            end
         end
         ST_WB: begin
            w_rf_we  = 1'b1;
            w_retire = 1'b1;
            w_next   = ST_FETCH;
         end
         ST_HALT: w_next = ST_HALT;
         default: w_next = ST_HALT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= ST_FETCH;
         r_cause   <= HC_NONE;
         r_retired <= '0;
      end else begin
         r_state <= w_next;
         r_cause <= w_cause_next;
         if (w_retire && (r_retired != '1)) begin
            r_retired <= r_retired + CNT_W'(1);
         end
      end
   end

`ifdef STALL_COUNT_EN
   logic [CNT_W-1:0] r_stall;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_stall <= '0;
      end else if (w_wait && (r_stall != '1)) begin
         r_stall <= r_stall + CNT_W'(1);
      end
   end

   assign stall_cycles = r_stall;
`endif

   // Reset masks every strobe combinationally so a same-cycle mem_ready cannot fire one.
   assign mem_req    = w_mem_req   & ~rst;
   assign mem_we     = w_mem_we    & ~rst;
   assign addr_sel   = w_addr_sel  & ~rst;
   assign pc_en      = w_pc_en     & ~rst;
   assign pc_sel     = w_pc_sel    & ~rst;
   assign ir_en      = w_ir_en     & ~rst;
   assign ab_en      = w_ab_en     & ~rst;
   assign aluout_en  = w_aluout_en & ~rst;
   assign mdr_en     = w_mdr_en    & ~rst;
   assign rf_we      = w_rf_we     & ~rst;
   assign halted     = (r_state == ST_HALT);
   assign halt_cause = r_cause;
   assign retired    = r_retired;

endmodule
